exec_controller: RTL and testbench

Run-control sequencer for the single-cycle core (PC, instruction memory, RF, ALU). It gates core advancement with a per-cycle enable and supports run, halt, single-step, one PC breakpoint and an instruction budget. It owns the core reset and streams a program into instruction memory before execution. A host or debug port drives it through a valid/ready command interface.

---
 rtl/exec_controller.sv | 178 +++++++++++++++++
 tb/tb_exec_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// rtl/exec_controller.sv - run-control sequencer for the single-cycle core
// Gates core advancement (run/halt/step/breakpoint/budget) and streams programs into instruction memory.
module exec_controller #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [2:0]        i_cmd_op,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_core_en,
  output logic              o_core_rst,
  output logic              o_instr_we,
  output logic [PC_W-1:0]   o_instr_addr,
  output logic [DATA_W-1:0] o_instr_wdata,
  output logic [2:0]        o_state,
  output logic [1:0]        o_halt_cause,
  output logic [CNT_W-1:0]  o_retired
);

  typedef enum logic [2:0] {
    S_CRST = 3'd0,
    S_HALT = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_LOAD = 3'd4
  } state_t;

  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_HALT      = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_SET_BP    = 3'd4;
  localparam logic [2:0] OP_CLR_BP    = 3'd5;
  localparam logic [2:0] OP_SET_LIMIT = 3'd6;
  localparam logic [2:0] OP_LOAD      = 3'd7;

  localparam logic [PC_W-1:0]   PC_ONE   = 1;
  localparam logic [DATA_W-1:0] DATA_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_bp_addr;
  logic              r_bp_valid;
  logic              r_limit_en;
  logic [CNT_W-1:0]  r_budget;
  logic              r_skip_bp;
  logic [DATA_W-1:0] r_load_cnt;
  logic [PC_W-1:0]   r_instr_addr;
  logic [CNT_W-1:0]  r_retired;
  logic [1:0]        r_halt_cause;

  logic w_fire;
  logic w_halt_fire;
  logic w_bp_match;
  logic w_budget_out;
  logic w_stop;
  logic w_cfg_op;

  assign o_cmd_ready  = (r_state == S_HALT) || (r_state == S_RUN) || (r_state == S_LOAD);
  assign w_fire       = i_cmd_valid && o_cmd_ready;
  assign w_halt_fire  = w_fire && (i_cmd_op == OP_HALT);
  assign w_bp_match   = r_bp_valid && (i_pc == r_bp_addr) && !r_skip_bp;
  assign w_budget_out = r_limit_en && (r_budget == '0);
  assign w_stop       = w_halt_fire || w_bp_match || w_budget_out;
  // Breakpoint/limit configuration is honoured in both HALT and RUN
  assign w_cfg_op     = w_fire && ((r_state == S_HALT) || (r_state == S_RUN));

  assign o_core_en     = ((r_state == S_RUN) && !w_stop) || (r_state == S_STEP);
  assign o_core_rst    = (r_state == S_CRST);
  assign o_instr_addr  = r_instr_addr;
  assign o_instr_wdata = i_cmd_data;
  assign o_state       = r_state;
  assign o_halt_cause  = r_halt_cause;
  assign o_retired     = r_retired;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_CRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_instr_we  = 1'b0;
    case (r_state)
      S_CRST: w_state_nxt = S_HALT;
      S_HALT: begin
        if (w_fire) begin
          case (i_cmd_op)
            OP_RUN:  w_state_nxt = S_RUN;
            OP_STEP: w_state_nxt = S_STEP;
            OP_LOAD: w_state_nxt = (i_cmd_data == '0) ? S_CRST : S_LOAD;
            default: w_state_nxt = S_HALT;
          endcase
        end
      end
      S_RUN: begin
        if (w_stop) w_state_nxt = S_HALT;
      end
      S_STEP: w_state_nxt = S_HALT;
      S_LOAD: begin
        o_instr_we = w_fire;
        if (w_fire && (r_load_cnt == DATA_ONE)) w_state_nxt = S_CRST;
      end
      default: w_state_nxt = S_CRST;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bp_addr    <= '0;
      r_bp_valid   <= 1'b0;
      r_limit_en   <= 1'b0;
      r_budget     <= '0;
      r_skip_bp    <= 1'b0;
      r_load_cnt   <= '0;
      r_instr_addr <= '0;
      r_retired    <= '0;
      r_halt_cause <= 2'd0;
    end else begin
      if (r_state == S_CRST) begin
        r_retired <= '0;
      end else if (o_core_en) begin
        r_retired <= r_retired + CNT_ONE;
      end

      if (r_state == S_RUN) begin
        if (o_core_en) r_skip_bp <= 1'b0;
        if (o_core_en && r_limit_en) r_budget <= r_budget - CNT_ONE;
        if (w_stop) r_halt_cause <= w_bp_match ? 2'd2 : (w_budget_out ? 2'd3 : 2'd1);
      end

      if ((r_state == S_HALT) && w_fire) begin
        case (i_cmd_op)
          OP_RUN: begin
            r_skip_bp    <= 1'b1;
            r_halt_cause <= 2'd0;
          end
          OP_STEP: r_halt_cause <= 2'd0;
          OP_LOAD: begin
            r_load_cnt   <= i_cmd_data;
            r_instr_addr <= '0;
          end
          default: ;
        endcase
      end

      // Placed after the RUN decrement so a fresh limit overrides it
      if (w_cfg_op) begin
        case (i_cmd_op)
          OP_SET_BP: begin
            r_bp_addr  <= PC_W'(i_cmd_data);
            r_bp_valid <= 1'b1;
          end
          OP_CLR_BP: r_bp_valid <= 1'b0;
          OP_SET_LIMIT: begin
            r_budget   <= CNT_W'(i_cmd_data);
            r_limit_en <= (i_cmd_data != '0);
          end
          default: ;
        endcase
      end

      if ((r_state == S_LOAD) && w_fire) begin
        r_instr_addr <= r_instr_addr + PC_ONE;
        r_load_cnt   <= r_load_cnt - DATA_ONE;
      end
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// tb/tb_exec_controller.sv - directed self-checking bench for exec_controller
// Drives commands after each rising edge, checks outputs half a cycle later.
module tb_exec_controller;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_HALT      = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_SET_BP    = 3'd4;
  localparam logic [2:0] OP_CLR_BP    = 3'd5;
  localparam logic [2:0] OP_SET_LIMIT = 3'd6;
  localparam logic [2:0] OP_LOAD      = 3'd7;

  localparam logic [31:0] WA = 32'hA5A5_0001;
  localparam logic [31:0] WB = 32'h1234_5678;
  localparam logic [31:0] WC = 32'hDEAD_BEEF;
  localparam logic [31:0] WD = 32'h0BAD_F00D;
  localparam logic [31:0] WE = 32'hCAFE_0042;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [31:0] pc;
  logic        core_en;
  logic        core_rst;
  logic        instr_we;
  logic [31:0] instr_addr;
  logic [31:0] instr_wdata;
  logic [2:0]  state;
  logic [1:0]  halt_cause;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;
  logic [31:0] bp;

  exec_controller #(.PC_W(32), .DATA_W(32), .CNT_W(32)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_data    (cmd_data),
    .i_pc          (pc),
    .o_core_en     (core_en),
    .o_core_rst    (core_rst),
    .o_instr_we    (instr_we),
    .o_instr_addr  (instr_addr),
    .o_instr_wdata (instr_wdata),
    .o_state       (state),
    .o_halt_cause  (halt_cause),
    .o_retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic v, input logic [2:0] op, input logic [31:0] d);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    #4;
  endtask

  // Clock edge plus a simple core PC: cleared by core_rst, advanced by core_en
  task automatic cyc();
    logic en_s;
    logic rst_s;
    en_s  = core_en;
    rst_s = core_rst;
    @(posedge clk);
    #1;
    if (rst_s) pc = 32'd0;
    else if (en_s) pc = pc + 32'd1;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0; pc = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_core_en", 64'(core_en), 64'd0);
    chk("rst_instr_we", 64'(instr_we), 64'd0);
    chk("rst_instr_addr", 64'(instr_addr), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_cause", 64'(halt_cause), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    cmd(0, OP_NOP, 0);
    chk("crst_hold", 64'(state), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("halt_after_crst", 64'(state), 64'd1);
    chk("halt_core_rst", 64'(core_rst), 64'd0);
    chk("halt_ready", 64'(cmd_ready), 64'd1);

    // program load of three words, with one idle cycle in between
    cmd(1, OP_LOAD, 32'd3); cyc();
    cmd(1, OP_NOP, WA);
    chk("load_state", 64'(state), 64'd4);
    chk("load0_we", 64'(instr_we), 64'd1);
    chk("load0_addr", 64'(instr_addr), 64'd0);
    chk("load0_data", 64'(instr_wdata), 64'(WA));
    chk("load_core_en", 64'(core_en), 64'd0);
    cyc(); cmd(0, OP_NOP, WB);
    chk("load_idle_we", 64'(instr_we), 64'd0);
    cyc(); cmd(1, OP_RUN, WB);
    chk("load1_we", 64'(instr_we), 64'd1);
    chk("load1_addr", 64'(instr_addr), 64'd1);
    chk("load1_data", 64'(instr_wdata), 64'(WB));
    cyc(); cmd(1, OP_HALT, WC);
    chk("load2_addr", 64'(instr_addr), 64'd2);
    chk("load2_data", 64'(instr_wdata), 64'(WC));
    cyc(); cmd(0, OP_NOP, 0);
    chk("post_load_crst", 64'(state), 64'd0);
    chk("post_load_core_rst", 64'(core_rst), 64'd1);
    chk("post_load_ready", 64'(cmd_ready), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("post_load_halt", 64'(state), 64'd1);
    chk("post_load_retired", 64'(retired), 64'd0);

    // breakpoint at pc 5
    cmd(1, OP_SET_BP, 32'd5); cyc();
    cmd(1, OP_RUN, 0); cyc();
    for (int i = 0; i < 5; i++) begin
      cmd(0, OP_NOP, 0);
      chk("bp_run_en", 64'(core_en), 64'd1);
      cyc();
    end
    cmd(0, OP_NOP, 0);
    chk("bp_hit_pc", 64'(pc), 64'd5);
    chk("bp_hit_en", 64'(core_en), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("bp_state", 64'(state), 64'd1);
    chk("bp_cause", 64'(halt_cause), 64'd2);
    chk("bp_retired", 64'(retired), 64'd5);

    // resume past the breakpoint, then halt by command
    cmd(1, OP_RUN, 0); cyc();
    cmd(0, OP_NOP, 0);
    chk("resume_en_at_bp", 64'(core_en), 64'd1);
    chk("resume_cause_clr", 64'(halt_cause), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("resume_en_pc6", 64'(core_en), 64'd1);
    chk("resume_state", 64'(state), 64'd2);
    cyc(); cmd(1, OP_HALT, 0);
    chk("haltcmd_en", 64'(core_en), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("haltcmd_state", 64'(state), 64'd1);
    chk("haltcmd_cause", 64'(halt_cause), 64'd1);
    chk("haltcmd_retired", 64'(retired), 64'd7);
    cmd(1, OP_CLR_BP, 0); cyc();

    // instruction budget of 4
    cmd(1, OP_SET_LIMIT, 32'd4); cyc();
    cmd(1, OP_RUN, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      cmd(0, OP_NOP, 0);
      chk("budget_en", 64'(core_en), 64'd1);
      cyc();
    end
    cmd(0, OP_NOP, 0);
    chk("budget_out_en", 64'(core_en), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("budget_state", 64'(state), 64'd1);
    chk("budget_cause", 64'(halt_cause), 64'd3);
    chk("budget_retired", 64'(retired), 64'd11);
    cmd(1, OP_RUN, 0); cyc();
    cmd(0, OP_NOP, 0);
    chk("budget_rerun_state", 64'(state), 64'd2);
    chk("budget_rerun_en", 64'(core_en), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("budget_rerun_halt", 64'(state), 64'd1);
    chk("budget_rerun_cause", 64'(halt_cause), 64'd3);
    chk("budget_rerun_retired", 64'(retired), 64'd11);
    cmd(1, OP_SET_LIMIT, 32'd0); cyc();

    // three single steps
    for (int k = 0; k < 3; k++) begin
      cmd(1, OP_STEP, 0);
      chk("step_from_halt", 64'(state), 64'd1);
      cyc(); cmd(0, OP_NOP, 0);
      chk("step_state", 64'(state), 64'd3);
      chk("step_en", 64'(core_en), 64'd1);
      chk("step_ready", 64'(cmd_ready), 64'd0);
      cyc();
    end
    cmd(0, OP_NOP, 0);
    chk("step_done_state", 64'(state), 64'd1);
    chk("step_retired", 64'(retired), 64'd14);

    // HALT command coinciding with a breakpoint match
    bp = pc + 32'd2;
    cmd(1, OP_SET_BP, bp); cyc();
    cmd(1, OP_RUN, 0); cyc();
    cmd(0, OP_NOP, 0); cyc();
    cmd(0, OP_NOP, 0); cyc();
    cmd(1, OP_HALT, 0);
    chk("both_pc", 64'(pc), 64'(bp));
    chk("both_en", 64'(core_en), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("both_state", 64'(state), 64'd1);
    chk("both_cause", 64'(halt_cause), 64'd2);
    chk("both_retired", 64'(retired), 64'd16);

    // empty load resets the core
    cmd(1, OP_LOAD, 32'd0); cyc();
    cmd(0, OP_NOP, 0);
    chk("load0_crst", 64'(state), 64'd0);
    cyc(); cmd(0, OP_NOP, 0);
    chk("load0_halt", 64'(state), 64'd1);
    chk("load0_retired", 64'(retired), 64'd0);

    // asynchronous reset in the middle of a load
    cmd(1, OP_LOAD, 32'd5); cyc();
    cmd(1, OP_NOP, WD);
    chk("mid_we0", 64'(instr_we), 64'd1);
    chk("mid_addr0", 64'(instr_addr), 64'd0);
    cyc(); cmd(1, OP_NOP, WE);
    chk("mid_addr1", 64'(instr_addr), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_addr", 64'(instr_addr), 64'd0);
    chk("arst_we", 64'(instr_we), 64'd0);
    chk("arst_core_rst", 64'(core_rst), 64'd1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(); cmd(0, OP_NOP, 0);
    chk("arst_recover", 64'(state), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
